// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, resolves JUMP
// locally, holds fetch across an outstanding BEQ and inserts load-use bubbles.
`ifndef IF_STAGE_OPCODES
`define IF_STAGE_OPCODES
`define _STALL 6'h3f
`define ADD    6'h01
`define SUB    6'h02
`define LDW    6'h10
`define SDW    6'h11
`define BEQ    6'h20
`define JUMP   6'h30
`endif

module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] STALL_WORD = {`_STALL, 26'b0}
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [2:0]  ld_rs_out,
  output logic [2:0]  ld_rt_out
);
  typedef enum logic {RUN, BR_WAIT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     pc_out_q, pc_out_d;
  logic [2:0]      ld_rs_q, ld_rs_d;
  logic [2:0]      ld_rt_q, ld_rt_d;
  logic [1:0]      hist_vld_q, hist_vld_d;
  logic [1:0][4:0] hist_dst_q, hist_dst_d;

  logic [5:0]      opcode;
  logic            has_src;
  logic            is_ldw;
  logic [1:0][4:0] src;
  logic [1:0]      use_hit;
  logic [1:0]      fwd_hit;

  assign opcode  = imem_data[31:26];
  assign is_ldw  = (opcode == `LDW);
  assign has_src = (opcode != `JUMP) && (opcode != `_STALL);
  assign src[0]  = imem_data[20:16];
  assign src[1]  = ((opcode == `SDW) || (opcode == `BEQ) || is_ldw) ?
                   imem_data[25:21] : imem_data[15:11];

  // slot0 match forces a bubble; slot1 match selects MEM load data in decode
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign use_hit[gi] = has_src && hist_vld_q[0] && (src[gi] == hist_dst_q[0]);
      assign fwd_hit[gi] = has_src && hist_vld_q[1] && (src[gi] == hist_dst_q[1]);
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = STALL_WORD;
    pc_out_d   = RESET_PC;
    ld_rs_d    = 3'd0;
    ld_rt_d    = 3'd0;
    hist_vld_d = {hist_vld_q[0], 1'b0};
    hist_dst_d = {hist_dst_q[0], 5'd0};

    case (state_q)
      RUN: begin
        if (use_hit == 2'b00) begin
          instr_d       = imem_data;
          pc_out_d      = pc_q;
          ld_rs_d       = {2'b00, fwd_hit[0]};
          ld_rt_d       = {2'b00, fwd_hit[1]};
          hist_vld_d[0] = is_ldw;
          hist_dst_d[0] = is_ldw ? imem_data[25:21] : 5'd0;
          if (opcode == `BEQ) begin
            pc_d    = pc_q + 32'd4;
            state_d = BR_WAIT;
          end else if (opcode == `JUMP) begin
            pc_d = {pc_q[31:28], imem_data[25:0], 2'b00};
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      BR_WAIT: begin
        if (br_valid) begin
          pc_d    = br_taken ? (br_target & ~32'h3) : pc_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= STALL_WORD;
      pc_out_q   <= RESET_PC;
      ld_rs_q    <= 3'd0;
      ld_rt_q    <= 3'd0;
      hist_vld_q <= '0;
      hist_dst_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      ld_rs_q    <= ld_rs_d;
      ld_rt_q    <= ld_rt_d;
      hist_vld_q <= hist_vld_d;
      hist_dst_q <= hist_dst_d;
    end
  end

  assign imem_addr = pc_q;
  assign instr_out = instr_q;
  assign pc_out    = pc_out_q;
  assign ld_rs_out = ld_rs_q;
  assign ld_rt_out = ld_rt_q;
endmodule
